// File: rtl/rotary_pkg.sv
// rotary_pkg: shared types for the rotary encoder front end.
//   quad_t     - debounced A/B position, encoded {A,B}
//   dir_t      - detent direction produced by the quadrature FSM
//   ACC_W      - width of the signed sub-step accumulator
//   quad_phase - maps a Gray position onto its 0..3 phase (S00=0, S10=1, S11=2, S01=3)
package rotary_pkg;
  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S10 = 2'b10, S11 = 2'b11} quad_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_CW = 2'd1, DIR_CCW = 2'd2} dir_t;
  localparam int ACC_W = 3;
  localparam logic signed [ACC_W:0] ACC_ONE = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W:0] ACC_FULL = (ACC_W + 1)'(4);
  function automatic logic [1:0] quad_phase(input quad_t s);
    return {s[0], s[1] ^ s[0]};
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-flop synchroniser plus stability counter for one raw input.
//   clk, rst (async, active low), din (raw asynchronous input),
//   dout (debounced level; changes after DEBOUNCE_CYC consecutive differing cycles)
module debounce_filter #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          hit;
  always_comb begin
    sync_d = {sync_q[0], din};
    hit    = (sync_q[1] != deb_q) && (cnt_q == CW'(DEBOUNCE_CYC - 1));
    cnt_d  = (sync_q[1] == deb_q || hit) ? '0 : cnt_q + 1'b1;
    deb_d  = hit ? sync_q[1] : deb_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  assign dout = deb_q;
endmodule

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: debounced A/B quadrature + push-switch decoder with bounded position counter.
//   clk, rst (async, active low), rotA/rotB/rotCenter (raw encoder pins),
//   en (enables count and step/press pulses), clr (sync load of CNT_INIT),
//   count (position), step_cw/step_ccw (detent pulses), press (press pulse),
//   held (debounced switch level), quad_err (illegal A/B transition pulse).
//   Optional ROT_ACCEL_EN: detents closer than ACCEL_WINDOW cycles move the count by ACCEL_STEP.
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int CNT_MIN      = 0,
  parameter int CNT_MAX      = 255,
  parameter int CNT_INIT     = 0,
  parameter bit WRAP         = 1'b1,
  parameter int DEBOUNCE_CYC = 16,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_STEP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rotA,
  input  logic             rotB,
  input  logic             rotCenter,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             press,
  output logic             held,
  output logic             quad_err
);
  logic a_db, b_db, c_db;
  debounce_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_a (.clk(clk), .rst(rst), .din(rotA), .dout(a_db));
  debounce_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_b (.clk(clk), .rst(rst), .din(rotB), .dout(b_db));
  debounce_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_c (.clk(clk), .rst(rst), .din(rotCenter), .dout(c_db));

  quad_t                   st_q, st_d, in_st;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  dir_t                    det_q, det_d;
  logic                    qerr_q, qerr_d;
  logic [1:0]              di;
  logic signed [ACC_W:0]   stp, sum;

  // Quadrature FSM: phase difference 1 = forward, 3 = reverse, 2 = both bits moved.
  always_comb begin
    in_st  = quad_t'({a_db, b_db});
    di     = quad_phase(in_st) - quad_phase(st_q);
    stp    = (di == 2'd1) ? ACC_ONE : (di == 2'd3) ? -ACC_ONE : '0;
    sum    = {acc_q[ACC_W-1], acc_q} + stp;
    st_d   = in_st;
    acc_d  = acc_q;
    det_d  = DIR_NONE;
    qerr_d = 1'b0;
    if (di == 2'd2) begin
      qerr_d = 1'b1;
      acc_d  = '0;
    end else if (in_st != st_q) begin
      if (in_st == S00) begin
        det_d = (sum == ACC_FULL) ? DIR_CW : (sum == -ACC_FULL) ? DIR_CCW : DIR_NONE;
        acc_d = '0;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             step_cw_q, step_cw_d, step_ccw_q, step_ccw_d;
  logic             press_q, press_d, c_prev_q, c_prev_d;
  logic             fast;
  int               step_amt, nxt, lim;

`ifdef ROT_ACCEL_EN
  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  always_comb begin
    fast  = tmr_q < TW'(ACCEL_WINDOW);
    tmr_d = (det_q != DIR_NONE) ? '0 : fast ? tmr_q + 1'b1 : tmr_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) tmr_q <= TW'(ACCEL_WINDOW);
    else      tmr_q <= tmr_d;
`else
  // No timer: a window is never negative, so every detent is slow.
  assign fast = ACCEL_WINDOW < 0;
`endif

  // Detent applied one edge after S00 entry; bounds handled in int to see the overshoot.
  always_comb begin
    step_amt   = fast ? ACCEL_STEP : 1;
    nxt        = int'(count_q) + ((det_q == DIR_CW) ? step_amt : (det_q == DIR_CCW) ? -step_amt : 0);
    lim        = (nxt > CNT_MAX) ? (WRAP ? CNT_MIN + nxt - CNT_MAX - 1 : CNT_MAX)
               : (nxt < CNT_MIN) ? (WRAP ? CNT_MAX - (CNT_MIN - nxt) + 1 : CNT_MIN)
               : nxt;
    count_d    = clr ? CNT_W'(CNT_INIT) : (en && det_q != DIR_NONE) ? CNT_W'(lim) : count_q;
    step_cw_d  = en && (det_q == DIR_CW);
    step_ccw_d = en && (det_q == DIR_CCW);
    press_d    = en && c_db && !c_prev_q;
    c_prev_d   = c_db;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q       <= S00;
      acc_q      <= '0;
      det_q      <= DIR_NONE;
      qerr_q     <= 1'b0;
      count_q    <= CNT_W'(CNT_INIT);
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      press_q    <= 1'b0;
      c_prev_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      acc_q      <= acc_d;
      det_q      <= det_d;
      qerr_q     <= qerr_d;
      count_q    <= count_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
      press_q    <= press_d;
      c_prev_q   <= c_prev_d;
    end

  assign count    = count_q;
  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign press    = press_q;
  assign held     = c_db;
  assign quad_err = qerr_q;
endmodule
